// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift sequence controller.
// Optional rotate feature is selected by SHIFT_SEQ_ROTATE_EN in shift_seq_ctrl.
package shift_seq_pkg;

  localparam int DEFAULT_WIDTH = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_seq_dp.sv
// Shift register datapath: parallel load has priority over a right shift
// that inserts the fill bit at the MSB.
module shift_seq_dp
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             fill,
  output logic [WIDTH-1:0] sreg
);

  logic [WIDTH-1:0] sreg_r;

  // Shift register storage with load and fill-shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sreg_r <= load_data;
    end else if (shift_en) begin
      sreg_r <= {fill, sreg_r[WIDTH-1:1]};
    end else begin
      sreg_r <= sreg_r;
    end
  end

  assign sreg = sreg_r;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequence controller: loads a word, shifts it out LSB-first for a
// programmed count, then pulses done. Define SHIFT_SEQ_ROTATE_EN for rot_mode.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             ser_in,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot_mode,
`endif
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [WIDTH-1:0] par_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0]       IDLE     = 2'(ST_IDLE);
  localparam logic [1:0]       SHIFT    = 2'(ST_SHIFT);
  localparam logic [1:0]       DONE     = 2'(ST_DONE);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] eff_cnt_s;
  logic             load_s;
  logic             shift_s;
  logic             fill_s;
  logic [WIDTH-1:0] sreg_s;
  logic             idle_r;
  logic             busy_r;
  logic             done_r;
  logic             ser_valid_r;

  // Zero or an over-range count means a full-width sequence
  always_comb begin
    eff_cnt_s = load_count;
    if ((load_count == CNT_ZERO) || (load_count > CNT_FULL)) begin
      eff_cnt_s = CNT_FULL;
    end else begin
      eff_cnt_s = load_count;
    end
  end

  // Next-state, counter and datapath control decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_valid) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = eff_cnt_s;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        // Abort wins even over the final shift, so no done pulse follows
        if (abort) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          shift_s   = 1'b1;
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = SHIFT;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and shift counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Status outputs registered from the next-state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_r      <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ser_valid_r <= 1'b0;
    end else begin
      idle_r      <= (state_nxt_s == IDLE);
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
      ser_valid_r <= (state_nxt_s == SHIFT);
    end
  end

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_r;

  // Rotate mode is captured once per sequence at load acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_r <= 1'b0;
    end else if (load_s) begin
      rot_r <= rot_mode;
    end else begin
      rot_r <= rot_r;
    end
  end

  assign fill_s = rot_r ? sreg_s[0] : ser_in;
`else
  assign fill_s = ser_in;
`endif

  shift_seq_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (load_data),
    .shift_en  (shift_s),
    .fill      (fill_s),
    .sreg      (sreg_s)
  );

  assign load_ready = idle_r & ~rst;
  assign ser_out    = sreg_s[0];
  assign ser_valid  = ser_valid_r;
  assign par_out    = sreg_s;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=4).
module tb_shift_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_data;
  logic [2:0] load_count;
  logic       ser_in;
  logic       abort;
  logic       ser_out;
  logic       ser_valid;
  logic [3:0] par_out;
  logic       busy;
  logic       done;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic       rot_mode;
`endif

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_count (load_count),
    .ser_in     (ser_in),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot_mode   (rot_mode),
`endif
    .abort      (abort),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .par_out    (par_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Load one word, collect the serial stream, and check latency and result
  task automatic run_seq(input string tag, input logic [3:0] d, input logic [2:0] c,
                         input logic si, input int exp_n, input logic [7:0] exp_bits,
                         input logic [3:0] exp_par);
    int         nv;
    int         lat;
    logic [7:0] bits;
    logic [3:0] par;
    logic       rdy;
    nv   = 0;
    lat  = 0;
    bits = 8'h00;
    par  = 4'h0;
    rdy  = 1'b1;
    load_data  = d;
    load_count = c;
    ser_in     = si;
    load_valid = 1'b1;
    chk({tag, "_ready"}, 32'(load_ready), 32'd1);
    tick;
    load_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (ser_valid) begin
        bits[nv[2:0]] = ser_out;
        nv++;
      end
      if (done) begin
        lat = i;
        par = par_out;
        rdy = load_ready;
        break;
      end
      tick;
    end
    chk({tag, "_nshift"}, 32'(nv), 32'(exp_n));
    chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
    chk({tag, "_done_lat"}, 32'(lat), 32'(exp_n + 1));
    chk({tag, "_par"}, 32'(par), 32'(exp_par));
    chk({tag, "_rdy_in_done"}, 32'(rdy), 32'd0);
    tick;
    chk({tag, "_rdy_after"}, 32'(load_ready), 32'd1);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic saw_done;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 4'h0;
    load_count = 3'd0;
    ser_in     = 1'b0;
    abort      = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_mode   = 1'b0;
`endif
    #1;
    chk("rst_par", 32'(par_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sv", 32'(ser_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_so", 32'(ser_out), 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(load_ready), 32'd1);

    run_seq("t1011", 4'b1011, 3'd4, 1'b0, 4, 8'b0000_1011, 4'b0000);
    run_seq("t0110", 4'b0110, 3'd2, 1'b1, 2, 8'b0000_0010, 4'b1101);
    run_seq("cnt0", 4'b1011, 3'd0, 1'b0, 4, 8'b0000_1011, 4'b0000);
    run_seq("cnt7", 4'b0011, 3'd7, 1'b1, 4, 8'b0000_0011, 4'b1111);
    run_seq("cnt1", 4'b0100, 3'd1, 1'b1, 1, 8'b0000_0000, 4'b1010);

    // Abort in the second SHIFT cycle
    load_data = 4'b1011; load_count = 3'd4; ser_in = 1'b0; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_ready", 32'(load_ready), 32'd1);
    chk("abt_par", 32'(par_out), 32'(4'b0101));
    chk("abt_done", 32'(done), 32'd0);
    chk("abt_sv", 32'(ser_valid), 32'd0);
    tick;
    chk("abt_done2", 32'(done), 32'd0);
    chk("abt_hold", 32'(par_out), 32'(4'b0101));

    // Abort on the final shift cycle suppresses shift and done
    load_data = 4'b0100; load_count = 3'd1; ser_in = 1'b1; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abtl_par", 32'(par_out), 32'(4'b0100));
    chk("abtl_busy", 32'(busy), 32'd0);
    chk("abtl_done", 32'(done), 32'd0);
    tick;
    chk("abtl_done2", 32'(done), 32'd0);

    // Abort is ignored in IDLE
    load_data = 4'b1011; load_count = 3'd4; ser_in = 1'b0;
    load_valid = 1'b1; abort = 1'b1;
    tick;
    load_valid = 1'b0; abort = 1'b0;
    chk("idle_abt_busy", 32'(busy), 32'd1);
    chk("idle_abt_sv", 32'(ser_valid), 32'd1);
    for (int i = 0; i < 5; i++) tick;
    chk("idle_abt_ready", 32'(load_ready), 32'd1);

    // Reset in the middle of SHIFT
    load_data = 4'b1011; load_count = 3'd4; ser_in = 1'b0; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    tick;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_par", 32'(par_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sv", 32'(ser_valid), 32'd0);
    chk("mid_rst_ready", 32'(load_ready), 32'd0);
    tick;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      saw_done = saw_done | done;
    end
    chk("mid_rst_nodone", 32'(saw_done), 32'd0);
    chk("mid_rst_ready2", 32'(load_ready), 32'd1);

`ifdef SHIFT_SEQ_ROTATE_EN
    rot_mode = 1'b1;
    run_seq("rot", 4'b1001, 3'd4, 1'b0, 4, 8'b0000_1001, 4'b1001);
    rot_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
